// File: rtl/fifo_rd_arbiter.sv
// Read-side scheduler for the async FIFO read domain.
// The single FIFO read port is shared among NREQ consumers using round-robin burst grants.
// Popped words leave through one registered valid/ready stage.
// Each word is tagged with its requester id and a last-beat flag.
module fifo_rd_arbiter #(
  parameter int DSIZE   = 8,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int BURST_W = 4
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*BURST_W-1:0] req_len,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  input  logic                    fifo_empty,
  input  logic [DSIZE-1:0]        fifo_rdata,
  output logic                    fifo_rd_inc,
  output logic [DSIZE-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDW-1:0]          out_id,
  output logic                    out_last
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } stateT;

  stateT              r_state;
  logic [NREQ-1:0]    r_grant;
  logic [IDW-1:0]     r_rrPtr;
  logic [IDW-1:0]     r_curId;
  logic [BURST_W:0]   r_remaining;
  logic [DSIZE-1:0]   r_outData;
  logic               r_outValid;
  logic [IDW-1:0]     r_outId;
  logic               r_outLast;

  logic               w_found;
  logic [IDW-1:0]     w_pickId;
  logic [BURST_W-1:0] w_pickLen;
  logic               w_pop;
  logic [IDW-1:0]     w_nextPtr;

  // Round-robin pick: the first asserted request scanning upward from r_rrPtr, wrapping at NREQ
  always_comb begin
    w_found   = 1'b0;
    w_pickId  = '0;
    w_pickLen = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && req[i] && (((int'(r_rrPtr) + k) % NREQ) == i)) begin
          w_found   = 1'b1;
          w_pickId  = IDW'(i);
          w_pickLen = req_len[i*BURST_W +: BURST_W];
        end
      end
    end
  end

  // Pop only inside a burst when the FIFO has data and the output register is free or draining
  assign w_pop     = (r_state == BURST) && !fifo_empty && (!r_outValid || out_ready);
  assign w_nextPtr = (r_curId == IDW'(NREQ - 1)) ? '0 : r_curId + IDW'(1);

  // Arbitration FSM and output register; a pop reloads the output word, otherwise an accept empties it
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_rrPtr     <= '0;
      r_curId     <= '0;
      r_remaining <= '0;
      r_outData   <= '0;
      r_outValid  <= 1'b0;
      r_outId     <= '0;
      r_outLast   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_outData  <= fifo_rdata;
        r_outValid <= 1'b1;
        r_outId    <= r_curId;
        r_outLast  <= (r_remaining == (BURST_W+1)'(1));
      end else if (r_outValid && out_ready) begin
        r_outValid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant     <= NREQ'(1) << w_pickId;
            r_remaining <= (BURST_W+1)'(w_pickLen) + (BURST_W+1)'(1);
            r_curId     <= w_pickId;
            r_state     <= BURST;
          end
        end
        BURST: begin
          if (w_pop) begin
            r_remaining <= r_remaining - (BURST_W+1)'(1);
            if (r_remaining == (BURST_W+1)'(1)) begin
              r_state <= IDLE;
              r_grant <= '0;
              r_rrPtr <= w_nextPtr;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign busy        = (r_state != IDLE);
  assign fifo_rd_inc = w_pop;
  assign out_data    = r_outData;
  assign out_valid   = r_outValid;
  assign out_id      = r_outId;
  assign out_last    = r_outLast;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Testbench for fifo_rd_arbiter.
// A queue stands in for the FIFO.
// The reference model expands each arbitration into its expected beat list (requester id and last flag).
// Expected data is simply the order in which words were written.
module tb_fifo_rd_arbiter;

  localparam int DSIZE   = 8;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int BURST_W = 4;

  logic                    rd_clk = 1'b0;
  logic                    rd_rst;
  logic [NREQ-1:0]         req;
  logic [NREQ*BURST_W-1:0] req_len;
  logic [NREQ-1:0]         grant;
  logic                    busy;
  logic                    fifo_empty;
  logic [DSIZE-1:0]        fifo_rdata;
  logic                    fifo_rd_inc;
  logic [DSIZE-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [IDW-1:0]          out_id;
  logic                    out_last;

  // FIFO contents, every word ever written, and the expected beat list indexed by global beat number
  logic [DSIZE-1:0] fifoQ[$];
  logic [DSIZE-1:0] pushedQ[$];
  int               expId[$];
  bit               expLast[$];

  int              popIdx;
  int              acceptIdx;
  int              mRr;
  int              burstsInPhase;
  int              phaseBursts;
  int              lenArr[NREQ];
  logic [NREQ-1:0] tbReq;
  bit              tbRst;
  int              readyPct;
  int              pushPct;
  bit              popPending;
  int              checkCount;
  int              passCount;

  fifo_rd_arbiter #(
    .DSIZE(DSIZE), .NREQ(NREQ), .IDW(IDW), .BURST_W(BURST_W)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .req(req), .req_len(req_len),
    .grant(grant), .busy(busy), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_rd_inc(fifo_rd_inc), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_id(out_id), .out_last(out_last)
  );

  // Free-running read-domain clock
  always #5 rd_clk = ~rd_clk;

  // Count every comparison and report any mismatch on one line
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
  endtask

  task automatic syncFifo();
    fifo_empty = (fifoQ.size() == 0);
    fifo_rdata = fifo_empty ? '0 : fifoQ[0];
  endtask

  task automatic pushWord();
    logic [DSIZE-1:0] w;
    w = DSIZE'($urandom);
    fifoQ.push_back(w);
    pushedQ.push_back(w);
  endtask

  // Drive reset, requests, lengths and random ready/push decisions for the coming cycle
  task automatic applyStimulus();
    rd_rst = tbRst;
    req    = tbReq;
    for (int i = 0; i < NREQ; i++) req_len[i*BURST_W +: BURST_W] = BURST_W'(lenArr[i]);
    out_ready = ($urandom_range(0, 99) < readyPct);
    if (($urandom_range(0, 99) < pushPct) && (fifoQ.size() < 24)) pushWord();
    syncFifo();
  endtask

  // Arbitration as seen from outside: the next requester from the round-robin pointer gets len+1 beats
  task automatic genBurst();
    int id;
    id = -1;
    if (tbReq == '0) begin
      checkOutput("unexpectedPop", fifo_rd_inc, 1'b0);
      expId.push_back(-1);
      expLast.push_back(1'b0);
      return;
    end
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (mRr + k) % NREQ;
      if (id < 0 && tbReq[c]) id = c;
    end
    for (int b = 0; b <= lenArr[id]; b++) begin
      expId.push_back(id);
      expLast.push_back(b == lenArr[id]);
    end
    mRr = (id + 1) % NREQ;
    burstsInPhase++;
    if (burstsInPhase >= phaseBursts) tbReq = '0;
  endtask

  // Score accepted beats, check pop legality and that the grant stays on the burst being popped
  task automatic modelStep();
    popPending = fifo_rd_inc;
    if (out_valid && out_ready) begin
      if (acceptIdx < popIdx) begin
        checkOutput("beatData", out_data, pushedQ[acceptIdx]);
        checkOutput("beatId", out_id, expId[acceptIdx]);
        checkOutput("beatLast", out_last, expLast[acceptIdx]);
        acceptIdx++;
      end else begin
        checkOutput("spuriousBeat", out_valid, 1'b0);
      end
    end
    if (fifo_rd_inc) begin
      checkOutput("popLegal", {fifo_empty, out_valid & ~out_ready}, 2'b00);
      if (popIdx >= expId.size()) genBurst();
    end
    if (popIdx < expId.size())
      checkOutput("grantHeld", {busy, grant}, {1'b1, NREQ'(1) << expId[popIdx]});
    if (fifo_rd_inc) popIdx++;
  endtask

  // One clock: retire the pop decided last cycle, drive new inputs, then sample
  task automatic tick();
    @(posedge rd_clk);
    #1;
    if (popPending && fifoQ.size() > 0) void'(fifoQ.pop_front());
    applyStimulus();
    #1;
    modelStep();
  endtask

  // Assert reset just after an edge; anything popped but not yet accepted is lost
  task automatic doReset();
    @(posedge rd_clk);
    #1;
    if (popPending && fifoQ.size() > 0) void'(fifoQ.pop_front());
    tbRst  = 1'b1;
    rd_rst = 1'b1;
    #1;
    checkOutput("rstGrant", grant, '0);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstValid", out_valid, 1'b0);
    checkOutput("rstPop", fifo_rd_inc, 1'b0);
    checkOutput("rstOutRegs", {out_data, out_id, out_last}, '0);
    popPending = 1'b0;
    while (expId.size() > popIdx) begin
      void'(expId.pop_back());
      void'(expLast.pop_back());
    end
    acceptIdx     = popIdx;
    mRr           = 0;
    tbReq         = '0;
    burstsInPhase = 0;
    phaseBursts   = 0;
  endtask

  // Run until every planned burst is popped and accepted, then confirm the arbiter sits idle
  task automatic runUntilDrained();
    int n;
    n = 0;
    while (!(popIdx == expId.size() && acceptIdx == popIdx && burstsInPhase >= phaseBursts) && n < 4000) begin
      tick();
      n++;
    end
    checkOutput("phaseDone", {popIdx == expId.size(), acceptIdx == popIdx, burstsInPhase >= phaseBursts}, 3'b111);
    repeat (2) begin
      tick();
      checkOutput("idleState", {busy, grant, fifo_rd_inc}, '0);
    end
  endtask

  task automatic runPhase(input logic [NREQ-1:0] mask, input int bursts, input int rPct, input int pPct);
    tbReq         = mask;
    phaseBursts   = bursts;
    burstsInPhase = 0;
    readyPct      = rPct;
    pushPct       = pPct;
    runUntilDrained();
  endtask

  // Directed scenarios first, then randomized phases
  initial begin
    int start;
    int n;
    int pcts[3];
    checkCount = 0;
    passCount  = 0;
    popIdx     = 0;
    acceptIdx  = 0;
    mRr        = 0;
    popPending = 1'b0;
    tbRst      = 1'b1;
    rd_rst     = 1'b1;
    tbReq      = '0;
    req        = '0;
    req_len    = '0;
    out_ready  = 1'b0;
    readyPct   = 100;
    pushPct    = 0;
    phaseBursts   = 0;
    burstsInPhase = 0;
    for (int i = 0; i < NREQ; i++) lenArr[i] = 0;
    repeat (6) pushWord();
    syncFifo();

    repeat (3) @(posedge rd_clk);
    #2;
    checkOutput("resetGrant", grant, '0);
    checkOutput("resetBusy", busy, 1'b0);
    checkOutput("resetValid", out_valid, 1'b0);
    checkOutput("resetOutRegs", {out_data, out_id, out_last}, '0);
    checkOutput("resetPop", fifo_rd_inc, 1'b0);

    // Single 4-beat burst for requester 1 with latency checks
    tbRst       = 1'b0;
    tbReq       = 4'b0010;
    lenArr[1]   = 3;
    phaseBursts = 1;
    pushPct     = 100;
    tick();
    checkOutput("firstCyclePop", fifo_rd_inc, 1'b0);
    checkOutput("grantLatency0", grant, '0);
    tick();
    checkOutput("grantLatency1", grant, 4'b0010);
    checkOutput("popLatency", fifo_rd_inc, 1'b1);
    tick();
    checkOutput("validLatency", out_valid, 1'b1);
    runUntilDrained();

    // Round robin over all requesters with single-beat bursts
    for (int i = 0; i < NREQ; i++) lenArr[i] = 0;
    runPhase(4'b1111, 8, 100, 100);

    // Maximum burst length, then a wrap of the round-robin pointer
    lenArr[3] = 15;
    runPhase(4'b1000, 1, 100, 100);
    runPhase(4'b1001, 1, 100, 100);

    // Backpressure and an empty-FIFO stall
    lenArr[2] = 3;
    runPhase(4'b0100, 2, 30, 100);
    lenArr[2] = 7;
    runPhase(4'b0100, 1, 100, 10);

    // Reset in the middle of a 6-beat burst; priority afterwards restarts at requester 0
    lenArr[2] = 0;
    runPhase(4'b0100, 1, 100, 100);
    lenArr[1]     = 5;
    tbReq         = 4'b0010;
    phaseBursts   = 1;
    burstsInPhase = 0;
    start = popIdx;
    n = 0;
    while (popIdx < start + 2 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("twoPopsBeforeReset", popIdx - start, 2);
    doReset();
    tick();
    tbRst         = 1'b0;
    tbReq         = 4'b1001;
    lenArr[0]     = 2;
    lenArr[3]     = 1;
    phaseBursts   = 1;
    burstsInPhase = 0;
    tick();
    checkOutput("postResetPop", fifo_rd_inc, 1'b0);
    runUntilDrained();

    // Randomized phases: request masks, lengths (biased to the extremes), ready and supply rates
    pcts[0] = 100;
    pcts[1] = 50;
    pcts[2] = 15;
    repeat (25) begin
      int rp;
      int pp;
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 3))
          0:       lenArr[i] = 0;
          1:       lenArr[i] = 15;
          default: lenArr[i] = int'($urandom_range(0, 15));
        endcase
      end
      rp = pcts[$urandom_range(0, 2)];
      pp = pcts[$urandom_range(0, 2)];
      runPhase(NREQ'($urandom_range(1, 15)), int'($urandom_range(1, 6)), rp, pp);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
